// File: rtl/crypto_src_arbiter_if.sv
// Operand-path handshake between the four operand sources/crypto core and the arbiter.
// The master side is the sources and the core; the slave side is crypto_src_arbiter.
interface crypto_src_arbiter_if;
    logic [3:0] req;
    logic       core_done;
    logic [1:0] select;
    logic [3:0] grant;
    logic       core_start;
    logic [3:0] done;
    logic       err;
    logic       busy;

    modport master (
        output req, core_done,
        input  select, grant, core_start, done, err, busy
    );

    modport slave (
        input  req, core_done,
        output select, grant, core_start, done, err, busy
    );
endinterface

// File: rtl/crypto_src_arbiter.sv
// Round-robin arbiter/sequencer for the shared 128-bit crypto core operand mux.
// Grants one source, pulses core_start, holds select until core_done or watchdog expiry.
module crypto_src_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    crypto_src_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    last_winner;
    logic [CW-1:0] cnt;
    logic [1:0]    winner;

    // Search from last_winner+1 upward; descending loop lets the nearest candidate win.
    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = 2'(last_winner + 2'd1);
        for (int i = 4; i >= 1; i--) begin
            if (bus.req[2'(last_winner + 2'(i))]) begin
                winner = 2'(last_winner + 2'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            last_winner    <= 2'd3;
            cnt            <= '0;
            bus.select     <= 2'd0;
            bus.grant      <= 4'd0;
            bus.core_start <= 1'b0;
            bus.done       <= 4'd0;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register updates from pre-edge values.
            bus.core_start <= 1'b0;
            bus.done       <= 4'd0;
            bus.err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        bus.grant      <= 4'b0001 << winner;
                        bus.select     <= winner;
                        bus.core_start <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // core_done takes priority over a coincident terminal count.
                    if (bus.core_done) begin
                        bus.done    <= bus.grant;
                        last_winner <= bus.select;
                        state       <= S_RELEASE;
                    end else if (cnt == LAST_CNT) begin
                        bus.err     <= 1'b1;
                        last_winner <= bus.select;
                        state       <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    bus.grant <= 4'd0;
                    bus.busy  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crypto_src_arbiter.sv
// Scoreboard bench for crypto_src_arbiter: dut0 (TIMEOUT=16) and dut1 (TIMEOUT=8).
// Stimulus pushes expected transactions; per-DUT monitors pop and compare on each release.
module tb_crypto_src_arbiter;
    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        bit         is_err;
        int         wait_n;
        int         period;
    } exp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [1:0][3:0] req_v;
    logic            core_done_v0;
    logic            core_done_v1;
    int              core_lat[2];

    logic [1:0][3:0] grant_m;
    logic [1:0][3:0] done_m;
    logic [1:0][1:0] select_m;
    logic [1:0]      start_m;
    logic [1:0]      err_m;
    logic [1:0]      busy_m;

    crypto_src_arbiter_if bus0 ();
    crypto_src_arbiter_if bus1 ();

    crypto_src_arbiter #(.TIMEOUT(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    crypto_src_arbiter #(.TIMEOUT(8))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.req       = req_v[0];
    assign bus0.core_done = core_done_v0;
    assign bus1.req       = req_v[1];
    assign bus1.core_done = core_done_v1;

    assign grant_m[0]  = bus0.grant;
    assign done_m[0]   = bus0.done;
    assign select_m[0] = bus0.select;
    assign start_m[0]  = bus0.core_start;
    assign err_m[0]    = bus0.err;
    assign busy_m[0]   = bus0.busy;
    assign grant_m[1]  = bus1.grant;
    assign done_m[1]   = bus1.done;
    assign select_m[1] = bus1.select;
    assign start_m[1]  = bus1.core_start;
    assign err_m[1]    = bus1.err;
    assign busy_m[1]   = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [3:0] gnt, input logic [1:0] sel,
                        input bit is_err, input int wait_n, input int period);
        exp_t e;
        e = '{grant: gnt, sel: sel, is_err: is_err, wait_n: wait_n, period: period};
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic check_zero(input int k);
        check($sformatf("dut%0d_zero_grant", k),  grant_m[k],  0);
        check($sformatf("dut%0d_zero_select", k), select_m[k], 0);
        check($sformatf("dut%0d_zero_start", k),  start_m[k],  0);
        check($sformatf("dut%0d_zero_done", k),   done_m[k],   0);
        check($sformatf("dut%0d_zero_err", k),    err_m[k],    0);
        check($sformatf("dut%0d_zero_busy", k),   busy_m[k],   0);
    endtask

    task automatic wait_release(input int k);
        int n = 0;
        bit seen;
        do begin
            @(negedge clk);
            n++;
            seen = (done_m[k] != 4'd0) || err_m[k];
        end while (!seen && n < 300);
        check($sformatf("dut%0d_release_seen", k), seen, 1);
    endtask

    task automatic wait_start(input int k);
        int n = 0;
        bit seen;
        do begin
            @(negedge clk);
            n++;
            seen = start_m[k];
        end while (!seen && n < 300);
        check($sformatf("dut%0d_start_seen", k), seen, 1);
    endtask

    // Core models: pulse core_done in the core_lat-th WAIT cycle; latency 0 never answers.
    initial begin
        core_done_v0 = 1'b0;
        forever begin
            @(negedge clk);
            if (start_m[0] && core_lat[0] > 0) begin
                repeat (core_lat[0]) @(negedge clk);
                core_done_v0 = 1'b1;
                @(negedge clk);
                core_done_v0 = 1'b0;
            end
        end
    end

    initial begin
        core_done_v1 = 1'b0;
        forever begin
            @(negedge clk);
            if (start_m[1] && core_lat[1] > 0) begin
                repeat (core_lat[1]) @(negedge clk);
                core_done_v1 = 1'b1;
                @(negedge clk);
                core_done_v1 = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mon
        bit         in_txn    = 1'b0;
        bit         have_prev = 1'b0;
        bit         stable;
        logic [3:0] cur_grant;
        logic [1:0] cur_sel;
        int         len;
        int         period;
        int         now = 0;
        int         prev_start;

        always @(negedge clk) begin
            exp_t e;
            bit   got;
            now++;
            if (rst) begin
                in_txn    = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (in_txn) begin
                    len++;
                    if (grant_m[g] !== cur_grant || select_m[g] !== cur_sel || busy_m[g] !== 1'b1)
                        stable = 1'b0;
                end
                if (start_m[g]) begin
                    check($sformatf("dut%0d_single_start", g), in_txn, 0);
                    in_txn     = 1'b1;
                    stable     = 1'b1;
                    len        = 0;
                    cur_grant  = grant_m[g];
                    cur_sel    = select_m[g];
                    period     = have_prev ? now - prev_start : 0;
                    prev_start = now;
                    have_prev  = 1'b1;
                end
                if (done_m[g] != 4'd0 || err_m[g]) begin
                    check($sformatf("dut%0d_release_in_txn", g), in_txn, 1);
                    if (in_txn) begin
                        got = 1'b0;
                        if (g == 0 && exp_q0.size() > 0) begin
                            e = exp_q0.pop_front();
                            got = 1'b1;
                        end else if (g == 1 && exp_q1.size() > 0) begin
                            e = exp_q1.pop_front();
                            got = 1'b1;
                        end
                        check($sformatf("dut%0d_expected_avail", g), got, 1);
                        if (got) begin
                            check($sformatf("dut%0d_grant", g),  cur_grant, e.grant);
                            check($sformatf("dut%0d_select", g), cur_sel,   e.sel);
                            check($sformatf("dut%0d_done", g),   done_m[g], e.is_err ? 4'd0 : e.grant);
                            check($sformatf("dut%0d_err", g),    err_m[g],  e.is_err);
                            check($sformatf("dut%0d_length", g), len,       e.wait_n + 1);
                            check($sformatf("dut%0d_stable", g), stable,    1);
                            if (e.period != 0)
                                check($sformatf("dut%0d_period", g), period, e.period);
                        end
                        in_txn = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        req_v       = '0;
        core_lat[0] = 1;
        core_lat[1] = 1;
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst = 1'b0;

        // All four requesting, single-cycle core: 0,1,2,3,0 every 4 cycles.
        push(0, 4'b0001, 2'd0, 0, 1, 0);
        push(0, 4'b0010, 2'd1, 0, 1, 4);
        push(0, 4'b0100, 2'd2, 0, 1, 4);
        push(0, 4'b1000, 2'd3, 0, 1, 4);
        push(0, 4'b0001, 2'd0, 0, 1, 4);
        req_v[0] = 4'b1111;
        for (int i = 0; i < 5; i++) wait_release(0);
        req_v[0] = 4'b0000;

        // Source 2 alone, core answers in the 10th WAIT cycle.
        core_lat[0] = 10;
        push(0, 4'b0100, 2'd2, 0, 10, 0);
        req_v[0] = 4'b0100;
        wait_release(0);
        req_v[0] = 4'b0000;
        @(negedge clk);
        check("idle_select_kept", select_m[0], 2);
        check("idle_grant_clear", grant_m[0],  0);
        check("idle_busy_clear",  busy_m[0],   0);

        // Timeout on source 0 (TIMEOUT=8), then source 1 wins over source 0.
        core_lat[1] = 0;
        push(1, 4'b0001, 2'd0, 1, 8, 0);
        req_v[1] = 4'b0001;
        wait_release(1);
        core_lat[1] = 1;
        push(1, 4'b0010, 2'd1, 0, 1, 0);
        req_v[1] = 4'b0011;
        wait_release(1);
        req_v[1] = 4'b0000;

        // core_done coincides with the terminal count: ok wins.
        core_lat[1] = 8;
        push(1, 4'b0001, 2'd0, 0, 8, 0);
        req_v[1] = 4'b0001;
        wait_release(1);
        req_v[1] = 4'b0000;

        // Reset mid-WAIT drops the transaction and restores source-0 priority.
        core_lat[0] = 0;
        req_v[0] = 4'b0010;
        wait_start(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        req_v[0]    = 4'b1001;
        core_lat[0] = 2;
        push(0, 4'b0001, 2'd0, 0, 2, 0);
        rst = 1'b0;
        wait_release(0);

        // Granted source drops mid-WAIT while source 3 raises its request.
        core_lat[0] = 5;
        push(0, 4'b0001, 2'd0, 0, 5, 0);
        push(0, 4'b1000, 2'd3, 0, 1, 0);
        req_v[0] = 4'b0001;
        wait_start(0);
        repeat (2) @(negedge clk);
        req_v[0]    = 4'b1000;
        core_lat[0] = 1;
        wait_release(0);
        wait_release(0);
        req_v[0] = 4'b0000;

        repeat (4) @(negedge clk);
        check("dut0_queue_drained", exp_q0.size(), 0);
        check("dut1_queue_drained", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
